// File: rtl/display_fb_writer.sv
// Double-buffered frame-buffer write controller: writes host pixels into the back bank, swaps on frame_start.
// Optional power-up clear of both banks under DISPLAY_FB_WRITER_CLEAR_EN.
module display_fb_writer #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 400,
  parameter int unsigned ADDR_W   = 18,
  parameter int unsigned DATA_W   = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              pix_sof,
  input  logic              frame_start,
  output logic              mem_we,
  output logic              mem_bank,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              disp_bank,
  output logic              swap,
  output logic              busy
);

  localparam int unsigned NPIX = H_ACTIVE * V_ACTIVE;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX - 1);

`ifdef DISPLAY_FB_WRITER_CLEAR_EN
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WAIT_SWAP, S_CLEAR} state_t;
  localparam state_t RESET_STATE = S_CLEAR;
  localparam logic   RESET_BUSY  = 1'b1;
  logic clr_bank;
`else
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WAIT_SWAP} state_t;
  localparam state_t RESET_STATE = S_IDLE;
  localparam logic   RESET_BUSY  = 1'b0;
`endif

  // A single-pixel frame is complete as soon as its sof beat is written.
  localparam state_t AFTER_FIRST = (NPIX == 1) ? S_WAIT_SWAP : S_WRITE;
  localparam logic [ADDR_W-1:0] PTR_AFTER_FIRST = (NPIX == 1) ? '0 : ADDR_W'(1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic              accept;
  logic              ready_nxt;
  logic              busy_nxt;

  assign accept = pix_valid && pix_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (accept && pix_sof) state_nxt = AFTER_FIRST;
      S_WRITE:     if (accept) begin
                     if (pix_sof)          state_nxt = AFTER_FIRST;
                     else if (ptr == LAST) state_nxt = S_WAIT_SWAP;
                   end
      S_WAIT_SWAP: if (frame_start) state_nxt = S_IDLE;
`ifdef DISPLAY_FB_WRITER_CLEAR_EN
      S_CLEAR:     if (ptr == LAST && !clr_bank) state_nxt = S_IDLE;
`endif
      default:     state_nxt = S_IDLE;
    endcase
    ready_nxt = (state_nxt == S_IDLE) || (state_nxt == S_WRITE);
    busy_nxt  = (state_nxt != S_IDLE);
`ifdef DISPLAY_FB_WRITER_CLEAR_EN
    // Hold the handshake closed for the cycle that shows the final clear write.
    if (state == S_CLEAR) begin
      ready_nxt = 1'b0;
      busy_nxt  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= RESET_STATE;
      ptr       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      disp_bank <= 1'b0;
      mem_bank  <= 1'b1;
      swap      <= 1'b0;
      pix_ready <= 1'b0;
      busy      <= RESET_BUSY;
`ifdef DISPLAY_FB_WRITER_CLEAR_EN
      clr_bank  <= 1'b1;
`endif
    end else begin
      state     <= state_nxt;
      pix_ready <= ready_nxt;
      busy      <= busy_nxt;
      mem_we    <= 1'b0;
      swap      <= 1'b0;
      mem_bank  <= ~disp_bank;
      case (state)
        S_IDLE, S_WRITE: begin
          if (accept && (pix_sof || state == S_WRITE)) begin
            mem_we    <= 1'b1;
            mem_wdata <= pix_data;
            if (pix_sof) begin
              mem_addr <= '0;
              ptr      <= PTR_AFTER_FIRST;
            end else begin
              mem_addr <= ptr;
              if (ptr != LAST) ptr <= ptr + ADDR_W'(1);
            end
          end
        end
        S_WAIT_SWAP: begin
          if (frame_start) begin
            disp_bank <= ~disp_bank;
            mem_bank  <= disp_bank;
            swap      <= 1'b1;
          end
        end
`ifdef DISPLAY_FB_WRITER_CLEAR_EN
        S_CLEAR: begin
          mem_we    <= 1'b1;
          mem_addr  <= ptr;
          mem_wdata <= '0;
          mem_bank  <= clr_bank;
          if (ptr == LAST) begin
            ptr      <= '0;
            clr_bank <= 1'b0;
          end else begin
            ptr <= ptr + ADDR_W'(1);
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_display_fb_writer.sv
// Directed self-checking bench for display_fb_writer with a 4x2 frame (NPIX=8).
module tb_display_fb_writer;

  localparam int unsigned ADDR_W = 18;
  localparam int unsigned DATA_W = 10;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              pix_valid;
  logic              pix_ready;
  logic [DATA_W-1:0] pix_data;
  logic              pix_sof;
  logic              frame_start;
  logic              mem_we;
  logic              mem_bank;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              disp_bank;
  logic              swap;
  logic              busy;

  int errors = 0;
  int checks = 0;

  display_fb_writer #(
    .H_ACTIVE(4),
    .V_ACTIVE(2),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .pix_sof    (pix_sof),
    .frame_start(frame_start),
    .mem_we     (mem_we),
    .mem_bank   (mem_bank),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .disp_bank  (disp_bank),
    .swap       (swap),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [DATA_W-1:0] frame_a [8];

`ifdef DISPLAY_FB_WRITER_CLEAR_EN
  localparam logic RST_BUSY = 1'b1;
`else
  localparam logic RST_BUSY = 1'b0;
`endif

  initial begin
    frame_a[0] = 10'h3FF;
    for (int i = 1; i < 8; i++) frame_a[i] = DATA_W'(i);

    reset_n = 1'b0; pix_valid = 1'b0; pix_data = '0; pix_sof = 1'b0; frame_start = 1'b0;
    step(); step();
    chk("rst_we",    32'(mem_we),    32'h0);
    chk("rst_addr",  32'(mem_addr),  32'h0);
    chk("rst_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_disp",  32'(disp_bank), 32'h0);
    chk("rst_bank",  32'(mem_bank),  32'h1);
    chk("rst_swap",  32'(swap),      32'h0);
    chk("rst_ready", 32'(pix_ready), 32'h0);
    chk("rst_busy",  32'(busy),      32'(RST_BUSY));
    reset_n = 1'b1;

`ifdef DISPLAY_FB_WRITER_CLEAR_EN
    for (int i = 0; i < 16; i++) begin
      step();
      chk("clr_we",    32'(mem_we),    32'h1);
      chk("clr_addr",  32'(mem_addr),  32'(i % 8));
      chk("clr_wdata", 32'(mem_wdata), 32'h0);
      chk("clr_bank",  32'(mem_bank),  32'(i < 8));
      chk("clr_ready", 32'(pix_ready), 32'h0);
    end
    step();
    chk("clr_done_we",    32'(mem_we),    32'h0);
    chk("clr_done_ready", 32'(pix_ready), 32'h1);
    chk("clr_done_busy",  32'(busy),      32'h0);
    chk("clr_done_disp",  32'(disp_bank), 32'h0);
    chk("clr_done_bank",  32'(mem_bank),  32'h1);
`else
    step();
    chk("idle_ready", 32'(pix_ready), 32'h1);
    chk("idle_busy",  32'(busy),      32'h0);
`endif

    // Full frame into bank 1, then swap.
    for (int i = 0; i < 8; i++) begin
      pix_valid = 1'b1; pix_sof = (i == 0); pix_data = frame_a[i];
      step();
      chk("full_we",    32'(mem_we),    32'h1);
      chk("full_addr",  32'(mem_addr),  32'(i));
      chk("full_wdata", 32'(mem_wdata), 32'(frame_a[i]));
      chk("full_bank",  32'(mem_bank),  32'h1);
      chk("full_ready", 32'(pix_ready), 32'(i != 7));
    end
    pix_valid = 1'b0; pix_sof = 1'b0;
    step();
    chk("wait_we",    32'(mem_we),    32'h0);
    chk("wait_addr",  32'(mem_addr),  32'h7);
    chk("wait_wdata", 32'(mem_wdata), 32'h7);
    chk("wait_busy",  32'(busy),      32'h1);
    chk("wait_swap",  32'(swap),      32'h0);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("swap1_swap",  32'(swap),      32'h1);
    chk("swap1_disp",  32'(disp_bank), 32'h1);
    chk("swap1_bank",  32'(mem_bank),  32'h0);
    chk("swap1_ready", 32'(pix_ready), 32'h1);
    chk("swap1_busy",  32'(busy),      32'h0);
    step();
    chk("swap1_pulse", 32'(swap), 32'h0);

    // Garbage beats in IDLE are accepted and dropped.
    for (int i = 0; i < 3; i++) begin
      pix_valid = 1'b1; pix_sof = 1'b0; pix_data = DATA_W'(10'h2A0 + i);
      step();
      chk("garb_we",    32'(mem_we),    32'h0);
      chk("garb_ready", 32'(pix_ready), 32'h1);
      chk("garb_busy",  32'(busy),      32'h0);
    end

    // Restart mid-frame after 5 beats, into bank 0.
    for (int i = 0; i < 5; i++) begin
      pix_valid = 1'b1; pix_sof = (i == 0); pix_data = DATA_W'(10'h100 + i);
      step();
      chk("pre_addr", 32'(mem_addr), 32'(i));
      chk("pre_bank", 32'(mem_bank), 32'h0);
    end
    pix_sof = 1'b1; pix_data = 10'h155;
    step();
    chk("rs_we",    32'(mem_we),    32'h1);
    chk("rs_addr",  32'(mem_addr),  32'h0);
    chk("rs_wdata", 32'(mem_wdata), 32'h155);
    chk("rs_swap",  32'(swap),      32'h0);
    chk("rs_disp",  32'(disp_bank), 32'h1);
    for (int i = 1; i < 4; i++) begin
      pix_sof = 1'b0; pix_data = DATA_W'(10'h0A0 + i);
      step();
      chk("rs_ptr_addr",  32'(mem_addr),  32'(i));
      chk("rs_ptr_wdata", 32'(mem_wdata), 32'(10'h0A0 + i));
      chk("rs_ptr_swap",  32'(swap),      32'h0);
    end

    // Reset at pointer 4 with a beat still offered.
    pix_data = 10'h0FF; reset_n = 1'b0;
    step();
    chk("mrst_we",    32'(mem_we),    32'h0);
    chk("mrst_addr",  32'(mem_addr),  32'h0);
    chk("mrst_wdata", 32'(mem_wdata), 32'h0);
    chk("mrst_disp",  32'(disp_bank), 32'h0);
    chk("mrst_bank",  32'(mem_bank),  32'h1);
    chk("mrst_swap",  32'(swap),      32'h0);
    chk("mrst_ready", 32'(pix_ready), 32'h0);
    chk("mrst_busy",  32'(busy),      32'(RST_BUSY));
`ifdef DISPLAY_FB_WRITER_CLEAR_EN
    pix_valid = 1'b0; reset_n = 1'b1;
    for (int i = 0; i < 17; i++) step();
`else
    pix_valid = 1'b0; reset_n = 1'b1;
    step();
`endif
    chk("mrst_ready_back", 32'(pix_ready), 32'h1);

    // Last pixel coincides with frame_start: no swap until the next frame_start.
    for (int i = 0; i < 8; i++) begin
      pix_valid = 1'b1; pix_sof = (i == 0); pix_data = DATA_W'(10'h200 + 3 * i);
      frame_start = (i == 7);
      step();
      chk("sim_addr",  32'(mem_addr),  32'(i));
      chk("sim_wdata", 32'(mem_wdata), 32'(10'h200 + 3 * i));
      chk("sim_bank",  32'(mem_bank),  32'h1);
    end
    pix_valid = 1'b0; pix_sof = 1'b0; frame_start = 1'b0;
    chk("sim_noswap", 32'(swap),      32'h0);
    chk("sim_disp",   32'(disp_bank), 32'h0);
    chk("sim_ready",  32'(pix_ready), 32'h0);
    step();
    chk("sim_noswap2", 32'(swap), 32'h0);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("sim_swap",  32'(swap),      32'h1);
    chk("sim_disp2", 32'(disp_bank), 32'h1);
    chk("sim_bank2", 32'(mem_bank),  32'h0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
